// File: rtl/fetch_unit.sv
// fetch_unit: PC, variable-latency imem handshake and IF/ID register for the WISC pipeline.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INS = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_decode,
  input  logic [1:0]  PC_source,
  input  logic [15:0] target_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  output logic [15:0] IF_ID_ins,
  output logic [15:0] IF_ID_pc_inc,
  output logic        IF_ID_valid,
  output logic [15:0] PC,
  output logic        fetch_halted
);
  localparam logic [1:0] FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
  logic [1:0] state, state_n;
  logic [15:0] fetch_addr, park, pc_n, word;
  logic redir, load;
  assign redir = PC_source == 2'b10;
  assign load = (state == FETCH && imem_done && !stall_decode) || (state == HOLD && !stall_decode);
  assign word = state == HOLD ? park : imem_data;
  assign imem_req = rst_n && (state == FETCH || state == DRAIN);
  assign imem_addr = fetch_addr;
  assign fetch_halted = state == HALTED;
  // an outstanding read must complete before a new address can be issued
  always_comb begin
    state_n = state;
    pc_n = PC;
    if (redir) begin
      pc_n = target_pc;
      state_n = (state == FETCH || state == DRAIN) && !imem_done ? DRAIN : FETCH;
    end else if (load) begin
      pc_n = fetch_addr + 16'd2;
      state_n = word[15:11] == 5'b0 ? HALTED : FETCH;
    end else if (state == FETCH && imem_done) state_n = HOLD;
    else if (state == DRAIN && imem_done) state_n = FETCH;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      PC <= RESET_PC;
      fetch_addr <= RESET_PC;
      park <= 16'h0;
      IF_ID_ins <= NOP_INS;
      IF_ID_pc_inc <= 16'h0;
      IF_ID_valid <= 1'b0;
    end else begin
      state <= state_n;
      PC <= pc_n;
      if (state_n == FETCH && !(state == FETCH && !imem_done)) fetch_addr <= pc_n;
      park <= redir ? 16'h0 : (state == FETCH && imem_done && stall_decode) ? imem_data : park;
      if (redir || (state == HALTED && !stall_decode)) begin
        IF_ID_ins <= NOP_INS;
        IF_ID_pc_inc <= 16'h0;
        IF_ID_valid <= 1'b0;
      end else if (load) begin
        IF_ID_ins <= word;
        IF_ID_pc_inc <= fetch_addr + 16'd2;
        IF_ID_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;
  localparam logic [15:0] NOP = 16'h0800;
  logic clk = 1'b0, rst_n = 1'b1, stall_decode = 1'b0, imem_done = 1'b0;
  logic [1:0] PC_source = 2'b00;
  logic [15:0] target_pc = 16'h0, imem_data = 16'h0;
  logic imem_req, IF_ID_valid, fetch_halted;
  logic [15:0] imem_addr, IF_ID_ins, IF_ID_pc_inc, PC;
  logic w_done = 1'b1, w_stall = 1'b0, w_req, w_valid, w_halted;
  logic [1:0] w_src = 2'b00;
  logic [15:0] w_data = 16'h1000, w_tgt = 16'h0, w_addr, w_ins, w_inc, w_pc;
  int checks = 0, failures = 0;
  logic [15:0] mem [0:32767];
  int cnt = 0, lat = 0, fixed_lat = 0;
  logic m_out, m_drop, m_park_v, m_halted, m_valid;
  logic [15:0] m_pc, m_addr, m_park, m_ins, m_inc;

  fetch_unit dut (.clk(clk), .rst_n(rst_n), .stall_decode(stall_decode), .PC_source(PC_source),
    .target_pc(target_pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_done(imem_done), .IF_ID_ins(IF_ID_ins), .IF_ID_pc_inc(IF_ID_pc_inc),
    .IF_ID_valid(IF_ID_valid), .PC(PC), .fetch_halted(fetch_halted));
  fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (.clk(clk), .rst_n(rst_n), .stall_decode(w_stall),
    .PC_source(w_src), .target_pc(w_tgt), .imem_req(w_req), .imem_addr(w_addr), .imem_data(w_data),
    .imem_done(w_done), .IF_ID_ins(w_ins), .IF_ID_pc_inc(w_inc), .IF_ID_valid(w_valid),
    .PC(w_pc), .fetch_halted(w_halted));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_out = 1'b1; m_drop = 1'b0; m_park_v = 1'b0; m_halted = 1'b0;
    m_pc = 16'h0; m_addr = 16'h0; m_park = 16'h0;
    m_ins = NOP; m_inc = 16'h0; m_valid = 1'b0;
  endtask

  task automatic deliver(input logic [15:0] w);
    m_ins = w; m_inc = m_addr + 16'd2; m_valid = 1'b1; m_pc = m_inc;
    m_halted = w[15:11] == 5'b0;
    m_out = !m_halted;
    m_addr = m_pc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_ins", IF_ID_ins, NOP);
    chk("rst_inc", IF_ID_pc_inc, 16'h0);
    chk("rst_valid", 16'(IF_ID_valid), 16'h0);
    chk("rst_pc", PC, 16'h0);
    chk("rst_halted", 16'(fetch_halted), 16'h0);
    m_reset();
    cnt = 0;
    imem_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock: memory responds, model advances, DUT outputs compared after the edge
  task automatic step(input logic stall, input logic [1:0] src, input logic [15:0] tgt);
    stall_decode = stall; PC_source = src; target_pc = tgt;
    #1;
    chk("imem_req", 16'(imem_req), 16'(m_out));
    if (m_out) chk("imem_addr", imem_addr, m_addr);
    if (!imem_req) cnt = 0;
    if (cnt == 0) lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(3));
    imem_done = imem_req && cnt >= lat;
    imem_data = imem_done ? mem[imem_addr[15:1]] : 16'($urandom);
    cnt = imem_done ? 0 : (imem_req ? cnt + 1 : 0);
    if (src == 2'b10) begin
      m_ins = NOP; m_inc = 16'h0; m_valid = 1'b0; m_park_v = 1'b0; m_halted = 1'b0; m_pc = tgt;
      if (m_out && !imem_done) m_drop = 1'b1;
      else begin m_out = 1'b1; m_drop = 1'b0; m_addr = tgt; end
    end else if (m_out && imem_done && m_drop) begin
      m_drop = 1'b0; m_addr = m_pc;
    end else if (m_out && imem_done && stall) begin
      m_park = imem_data; m_park_v = 1'b1; m_out = 1'b0;
    end else if (m_out && imem_done) deliver(imem_data);
    else if (m_park_v && !stall) begin m_park_v = 1'b0; deliver(m_park); end
    else if (m_halted && !stall) begin m_ins = NOP; m_inc = 16'h0; m_valid = 1'b0; end
    @(posedge clk);
    #1;
    chk("IF_ID_ins", IF_ID_ins, m_ins);
    chk("IF_ID_pc_inc", IF_ID_pc_inc, m_inc);
    chk("IF_ID_valid", 16'(IF_ID_valid), 16'(m_valid));
    chk("PC", PC, m_pc);
    chk("fetch_halted", 16'(fetch_halted), 16'(m_halted));
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i << 1) | 16'h1000;
    #2;
    do_reset();
    #1;
    chk("wrap_first_addr", w_addr, 16'hFFFE);
    chk("wrap_first_req", 16'(w_req), 16'h1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'b00, 16'h0);
      chk("seq_ins", IF_ID_ins, 16'h1000 + 16'(2 * k));
      chk("seq_inc", IF_ID_pc_inc, 16'(2 * k + 2));
      if (k == 0) begin
        chk("wrap_inc", w_inc, 16'h0000);
        chk("wrap_second_addr", w_addr, 16'h0000);
      end
    end
    step(1'b0, 2'b10, 16'h0004);
    fixed_lat = 2;
    step(1'b0, 2'b00, 16'h0);
    step(1'b0, 2'b00, 16'h0);
    step(1'b1, 2'b00, 16'h0);
    chk("hold_req", 16'(imem_req), 16'h0);
    step(1'b1, 2'b00, 16'h0);
    step(1'b1, 2'b00, 16'h0);
    chk("hold_frozen_valid", 16'(IF_ID_valid), 16'h0);
    step(1'b0, 2'b00, 16'h0);
    chk("park_ins", IF_ID_ins, 16'h1004);
    chk("park_inc", IF_ID_pc_inc, 16'h0006);
    chk("park_next_addr", imem_addr, 16'h0006);
    fixed_lat = 3;
    step(1'b0, 2'b10, 16'h0040);
    chk("redir_valid", 16'(IF_ID_valid), 16'h0);
    chk("redir_pc", PC, 16'h0040);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) chk("drain_addr", imem_addr, 16'h0006);
      step(1'b0, 2'b00, 16'h0);
    end
    chk("drain_next_addr", imem_addr, 16'h0040);
    chk("drain_valid", 16'(IF_ID_valid), 16'h0);
    fixed_lat = 0;
    step(1'b1, 2'b10, 16'h0020);
    chk("flush_ins", IF_ID_ins, NOP);
    chk("flush_req", 16'(imem_req), 16'h1);
    chk("flush_addr", imem_addr, 16'h0020);
    mem[4] = 16'h0000;
    step(1'b0, 2'b10, 16'h0008);
    step(1'b0, 2'b00, 16'h0);
    chk("halt_flag", 16'(fetch_halted), 16'h1);
    chk("halt_ins", IF_ID_ins, 16'h0000);
    chk("halt_pc", PC, 16'h000A);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 2'b00, 16'h0);
      chk("halt_req", 16'(imem_req), 16'h0);
    end
    chk("halt_pc_held", PC, 16'h000A);
    step(1'b0, 2'b10, 16'h0000);
    chk("resume_req", 16'(imem_req), 16'h1);
    chk("resume_addr", imem_addr, 16'h0000);
    step(1'b1, 2'b00, 16'h0);
    chk("async_hold_req", 16'(imem_req), 16'h0);
    #2;
    do_reset();
    for (int i = 0; i < 64; i++)
      mem[i] = $urandom_range(9) == 0 ? 16'h0000 : {5'($urandom_range(31, 1)), 11'($urandom)};
    fixed_lat = -1;
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] src;
      logic [15:0] tgt;
      src = $urandom_range(5) == 0 ? 2'b10 : 2'($urandom_range(1));
      tgt = $urandom_range(7) == 0 ? 16'hFFFC : 16'($urandom_range(63)) << 1;
      step($urandom_range(9) < 3, src, tgt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
